gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter width in bits; legal range 2..16.
REQ-002 Port clk, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port en, input, 1 bit: count enable, sampled on the rising edge of clk.
REQ-005 Port up_dn, input, 1 bit: count direction, 1 = increment, 0 = decrement.
REQ-006 Port load, input, 1 bit: when high, loads bin_in on the next rising edge.
REQ-007 Port bin_in, input, WIDTH bits: binary load value.
REQ-008 Port gray, output, WIDTH bits: registered Gray code of the current count.
REQ-009 Port bin, output, WIDTH bits: registered binary value of the current count.
REQ-010 Port wrap, output, 1 bit: single-cycle pulse on count wrap-around or saturation hit.

Function
REQ-011 The block SHALL hold a WIDTH-bit binary count register and a WIDTH-bit Gray register, both updated on the same clock edge.
REQ-012 The Gray value SHALL always equal next_bin XOR (next_bin >> 1), computed from the next binary value and registered. gray SHALL never be derived combinationally from bin at the output.
REQ-013 Update priority on each edge SHALL be rst > load > en; when all three are low, the state SHALL hold.
REQ-014 On load, bin SHALL become bin_in and gray SHALL become its Gray code, both visible one cycle later; wrap SHALL be 0.
REQ-015 On en with up_dn=1, the count SHALL increment modulo 2^WIDTH; on en with up_dn=0, it SHALL decrement modulo 2^WIDTH.
REQ-016 Latency from a sampled en, load or rst to the updated outputs SHALL be exactly one clock.
REQ-017 Between consecutive counted values, gray SHALL differ in exactly one bit, including across wrap-around.
REQ-018 wrap SHALL be 1 for exactly one cycle, in the cycle after an increment from all-ones to 0 or a decrement from 0 to all-ones; it SHALL be 0 otherwise.
REQ-019 If load and en are high together, load SHALL win, the count SHALL not step, and wrap SHALL be 0.
REQ-020 A change of up_dn while en is high SHALL take effect on the same edge at which it is sampled, with no lost or extra step.

Reset
REQ-021 With rst high at a rising edge, bin SHALL be 0, gray SHALL be 0 and wrap SHALL be 0 in the next cycle, regardless of load or en.
REQ-022 A reset asserted mid-count SHALL discard the count without producing a wrap pulse; counting SHALL resume from 0 on the first enabled edge after rst drops.

Configuration
REQ-023 Macro GRAY_SAT_EN: when defined, the counter SHALL saturate, holding at all-ones on increment and at 0 on decrement. wrap SHALL pulse one cycle only on the edge that first reaches the limit from a non-limit value, and further enabled steps at the limit SHALL leave the state and wrap unchanged at 0.
REQ-024 When GRAY_SAT_EN is undefined, the modulo behaviour of REQ-015 and REQ-018 SHALL apply. Port list, reset values and latency SHALL be identical in both builds.

Verification (WIDTH=4)
REQ-025 Reset, then en=1 and up_dn=1 for 16 cycles -> gray SHALL be 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, then 0 with wrap=1 for exactly one cycle (modulo build).
REQ-026 load=1 with bin_in=9 -> next cycle bin=9, gray=4'b1101, wrap=0.
REQ-027 From reset, en=1 and up_dn=0 for one edge -> bin=15, gray=4'b1000, wrap=1 (modulo build). In the GRAY_SAT_EN build -> bin=0, gray=0, wrap=0.
REQ-028 load=1, en=1, bin_in=15, up_dn=1 on the same edge -> bin=15, gray=4'b1000, wrap=0; on the next enabled edge -> bin=0 and wrap=1 (modulo build), or bin=15 and wrap=0 (GRAY_SAT_EN build).
REQ-029 Count up to bin=6, assert rst together with en and load for one edge -> bin=0, gray=0, wrap=0; after rst drops, the first enabled increment -> bin=1, gray=1.
REQ-030 Throughout all scenarios, a bench checker SHALL confirm that gray equals bin XOR (bin >> 1) every cycle and that Hamming distance between gray values is 1 across every counted step.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code output, load and wrap pulse.
// Define GRAY_SAT_EN to make the counter saturate at 0 / all-ones instead of wrapping.
module gray_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] bin_in,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = bin_in;
        end else if (en) begin
            if (up_dn) begin
`ifdef GRAY_SAT_EN
                if (bin_q != '1) begin
                    bin_d  = bin_q + 1'b1;
                    wrap_d = (bin_d == '1);
                end
`else
                bin_d  = bin_q + 1'b1;
                wrap_d = (bin_q == '1);
`endif
            end else begin
`ifdef GRAY_SAT_EN
                if (bin_q != '0) begin
                    bin_d  = bin_q - 1'b1;
                    wrap_d = (bin_d == '0);
                end
`else
                bin_d  = bin_q - 1'b1;
                wrap_d = (bin_q == '0);
`endif
            end
        end
        // Gray is encoded from the next binary value so both registers agree on every edge.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed self-checking bench for gray_counter (WIDTH=4); expectations follow GRAY_SAT_EN.
module tb_gray_counter;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, load;
    logic [W-1:0] bin_in;
    logic [W-1:0] gray, bin;
    logic         wrap;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        mon_en   = 1'b0;
    logic        stepped  = 1'b0;
    logic [W-1:0] prev_gray, prev_bin;

    logic [W-1:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                    4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    gray_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .up_dn  (up_dn),
        .load   (load),
        .bin_in (bin_in),
        .gray   (gray),
        .bin    (bin),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int b, input int g, input int w);
        check({tag, ".bin"},  32'(bin),  32'(b));
        check({tag, ".gray"}, 32'(gray), 32'(g));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    // Track which edges were counting steps for the single-bit-change check.
    always @(posedge clk) begin
        stepped   <= en && !load && !rst;
        prev_gray <= gray;
        prev_bin  <= bin;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("gray_inv", 32'(gray), 32'(bin ^ (bin >> 1)));
            if (stepped && (prev_bin != bin))
                check("hamming1", 32'($countones(prev_gray ^ gray)), 32'd1);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; bin_in = '0;
        step();
        expect_state("reset", 0, 0, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Full up-count sweep through wrap / saturation
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
`ifdef GRAY_SAT_EN
            expect_state($sformatf("up%0d", i), (i > 15) ? 15 : i,
                         gray_tbl[(i > 15) ? 15 : i], (i == 15) ? 1 : 0);
`else
            expect_state($sformatf("up%0d", i), i % 16, gray_tbl[i % 16], (i == 16) ? 1 : 0);
`endif
        end

        en = 1'b0;
        step(); step();
`ifdef GRAY_SAT_EN
        expect_state("hold", 15, 8, 0);
`else
        expect_state("hold", 1, 1, 0);
`endif

        load = 1'b1; bin_in = 4'd9;
        step();
        expect_state("load9", 9, 13, 0);
        load = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b1; up_dn = 1'b0;
        step();
`ifdef GRAY_SAT_EN
        expect_state("dn_from0", 0, 0, 0);
`else
        expect_state("dn_from0", 15, 8, 1);
`endif
        en = 1'b0;
        step();
        check("wrap_one_cycle", 32'(wrap), 32'd0);

        load = 1'b1; en = 1'b1; bin_in = 4'd15; up_dn = 1'b1;
        step();
        expect_state("load_wins", 15, 8, 0);
        load = 1'b0;
        step();
`ifdef GRAY_SAT_EN
        expect_state("after_load15", 15, 8, 0);
`else
        expect_state("after_load15", 0, 0, 1);
`endif

        load = 1'b1; bin_in = 4'd5; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        step(); expect_state("dir_up6", 6, 5, 0);
        up_dn = 1'b0;
        step(); expect_state("dir_dn5", 5, 7, 0);
        step(); expect_state("dir_dn4", 4, 6, 0);
        up_dn = 1'b1;
        step(); expect_state("dir_up5", 5, 7, 0);

        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 6; i++) step();
        expect_state("cnt6", 6, 5, 0);
        rst = 1'b1; load = 1'b1; bin_in = 4'd12;
        step();
        expect_state("rst_mid", 0, 0, 0);
        rst = 1'b0; load = 1'b0;
        step();
        expect_state("resume", 1, 1, 0);

        load = 1'b1; bin_in = 4'd1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        step();
`ifdef GRAY_SAT_EN
        expect_state("dn_to0", 0, 0, 1);
        step();
        expect_state("dn_at0", 0, 0, 0);
`else
        expect_state("dn_to0", 0, 0, 0);
        step();
        expect_state("dn_wrap", 15, 8, 1);
`endif

        en = 1'b0;
        step(); step();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
